input_trigger_multi: RTL

- Parametrised successor of the single-mode input trigger. Monitors CHANNELS asynchronous-to-logic button/strobe inputs.
- Per channel: selectable edge qualification (rising / falling / both / off) plus an enable mask.
- On a qualified event it issues one increment pulse tagged with the set of firing channels. After a settle window it issues one refresh pulse, then a debounce lockout.
- Counts events lost to lockout. Sits between the pad inputs and the digit counter / display refresh logic.

---
 rtl/input_trigger_multi.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/input_trigger_multi.sv
// -----------------------------------------------------------------------------
// input_trigger_multi
//
// Purpose:
//   Watches CHANNELS raw trigger levels (buttons/strobes) and turns qualified
//   edges into a clean two-pulse sequence for the downstream digit counter and
//   display:
//     READY --event--> SETTLE (inc_clk on first cycle)
//           --> REFRESH (ref_clk for one cycle)
//           --> BLOCK (debounce lockout) --> READY
//   Events that arrive while not READY are counted in a saturating
//   missed-event counter.
//
// Optional feature (macro INPUT_TRIGGER_PENDING_EN):
//   When defined, events outside READY are queued in a per-channel pending
//   register and fired on the first READY cycle. missed_cnt then counts only
//   events that hit an already-pending channel. When undefined, every event
//   outside READY is dropped and counted.
//
// Ports:
//   clk         in   1         system clock
//   rst_n       in   1         synchronous active-low reset
//   trigger     in   CHANNELS  raw trigger levels
//   ch_en       in   CHANNELS  per-channel enable (0 = never qualifies)
//   edge_mode   in   2         00 rise, 01 fall, 10 both, 11 all off
//   inc_clk     out  1         one-cycle increment pulse
//   inc_mask    out  CHANNELS  channels that fired (held until next fire)
//   ref_clk     out  1         one-cycle refresh pulse
//   busy        out  1         high whenever state != READY
//   missed_cnt  out  MISS_W    saturating count of dropped events
// -----------------------------------------------------------------------------
module input_trigger_multi #(
   parameter int CHANNELS        = 6,
   parameter int SETTLE_CYCLES   = 16,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int MISS_W          = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] trigger,
   input  logic [CHANNELS-1:0] ch_en,
   input  logic [1:0]          edge_mode,
   output logic                inc_clk,
   output logic [CHANNELS-1:0] inc_mask,
   output logic                ref_clk,
   output logic                busy,
   output logic [MISS_W-1:0]   missed_cnt
);

   // Counter must reach the larger of the two window lengths without wrapping.
   localparam int MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]    BLOCK_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [MISS_W-1:0]   MISS_ZERO   = {MISS_W{1'b0}};
   localparam logic [MISS_W-1:0]   MISS_ONE    = MISS_W'(1);
   localparam logic [MISS_W-1:0]   MISS_MAX    = {MISS_W{1'b1}};
   localparam logic [CHANNELS-1:0] CH_ZERO     = {CHANNELS{1'b0}};

   typedef enum logic [1:0] {
      READY   = 2'd0,
      SETTLE  = 2'd1,
      REFRESH = 2'd2,
      BLOCK   = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [CHANNELS-1:0] trig_q;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] sel;
   logic [CHANNELS-1:0] ev;
   logic [CHANNELS-1:0] fire_vec;
   logic                miss_hit;

`ifdef INPUT_TRIGGER_PENDING_EN
   logic [CHANNELS-1:0] pending;
`endif

   // Edge detection and qualification; mode and enables are used live.
   always_comb begin
      rise = trigger & ~trig_q;
      fall = ~trigger & trig_q;
      sel  = CH_ZERO;
      case (edge_mode)
         2'b00:   sel = rise;
         2'b01:   sel = fall;
         2'b10:   sel = rise | fall;
         default: sel = CH_ZERO;
      endcase
      ev = ch_en & sel;
`ifdef INPUT_TRIGGER_PENDING_EN
      // Queued events fire alongside fresh ones; a miss is a re-hit on a
      // channel that is already queued.
      fire_vec = ev | pending;
      miss_hit = |(ev & pending);
`else
      fire_vec = ev;
      miss_hit = |ev;
`endif
   end

   // Main sequencer: state, window counter, registered pulses and miss count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= READY;
         cnt        <= CNT_ZERO;
         trig_q     <= CH_ZERO;
         inc_clk    <= 1'b0;
         inc_mask   <= CH_ZERO;
         ref_clk    <= 1'b0;
         busy       <= 1'b0;
         missed_cnt <= MISS_ZERO;
`ifdef INPUT_TRIGGER_PENDING_EN
         pending    <= CH_ZERO;
`endif
      end else begin
         // Track the input in every state so returning to READY never sees
         // a stale edge.
         trig_q <= trigger;

         case (state)
            READY: begin
               ref_clk <= 1'b0;
               if (|fire_vec) begin
                  state    <= SETTLE;
                  inc_clk  <= 1'b1;
                  inc_mask <= fire_vec;
                  busy     <= 1'b1;
                  cnt      <= CNT_ZERO;
`ifdef INPUT_TRIGGER_PENDING_EN
                  pending  <= CH_ZERO;
`endif
               end else begin
                  inc_clk <= 1'b0;
                  busy    <= 1'b0;
               end
            end

            SETTLE: begin
               // inc_clk was set on entry, so it is high only on the first
               // SETTLE cycle.
               inc_clk <= 1'b0;
               if (cnt == SETTLE_LAST) begin
                  state   <= REFRESH;
                  ref_clk <= 1'b1;
                  cnt     <= CNT_ZERO;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            REFRESH: begin
               inc_clk <= 1'b0;
               ref_clk <= 1'b0;
               state   <= BLOCK;
               cnt     <= CNT_ZERO;
            end

            BLOCK: begin
               inc_clk <= 1'b0;
               ref_clk <= 1'b0;
               if (cnt == BLOCK_LAST) begin
                  state <= READY;
                  busy  <= 1'b0;
                  cnt   <= CNT_ZERO;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            default: begin
               state   <= READY;
               inc_clk <= 1'b0;
               ref_clk <= 1'b0;
               busy    <= 1'b0;
               cnt     <= CNT_ZERO;
            end
         endcase

         // One increment per cycle with a drop, whatever the number of bits.
         if ((state != READY) && miss_hit && (missed_cnt != MISS_MAX)) begin
            missed_cnt <= missed_cnt + MISS_ONE;
         end else begin
            missed_cnt <= missed_cnt;
         end

`ifdef INPUT_TRIGGER_PENDING_EN
         if (state != READY) begin
            pending <= pending | ev;
         end else begin
            pending <= (|fire_vec) ? CH_ZERO : pending;
         end
`endif
      end
   end

endmodule
